// File: rtl/instr_encoder_loader.sv
// Instruction encoder and program loader: packs streamed fields into 32-bit MIPS-Lite
// words and writes them sequentially into instruction memory until HALT.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, waiting for start
// LOAD  | accepting fields, one encoded word written per accept
// DONE  | HALT written, holding until the next start
// ERROR | illegal opcode or memory full, holding until the next start
module instr_encoder_loader #(
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [5:0]        i_in_opcode,
    input  logic [4:0]        i_in_rs,
    input  logic [4:0]        i_in_rt,
    input  logic [4:0]        i_in_rd,
    input  logic [15:0]       i_in_imm,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_instr_count,
    output logic              o_err_illegal,
    output logic              o_err_overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [5:0] OP_JR   = 6'h10;
    localparam logic [5:0] OP_HALT = 6'h11;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_count;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_err_illegal;
    logic                r_err_overflow;

    logic                w_accept;
    logic                w_is_halt;
    logic                w_is_jr;
    logic                w_is_illegal;
    logic                w_is_rtype;
    logic                w_is_itype;
    logic                w_last;
    logic [31:0]         w_word;
    logic                w_clear;
    logic                w_write;
    logic                w_set_ill;
    logic                w_set_ovf;

    assign w_accept     = i_in_valid && (r_state == S_LOAD);
    assign w_is_halt    = (i_in_opcode == OP_HALT);
    assign w_is_jr      = (i_in_opcode == OP_JR);
    assign w_is_illegal = (i_in_opcode > OP_HALT);
    // Opcodes 0x00..0x0B alternate R/I by the low bit; 0x0C..0x0F are all I-type.
    assign w_is_rtype   = (i_in_opcode <= 6'h0B) && !i_in_opcode[0];
    assign w_is_itype   = !w_is_illegal && !w_is_halt && !w_is_jr && !w_is_rtype;
    assign w_last       = (r_addr == ADDR_W'(DEPTH - 1));

    always_comb begin
        w_word        = '0;
        w_word[31:26] = i_in_opcode;
        if (w_is_rtype) begin
            w_word[25:21] = i_in_rs;
            w_word[20:16] = i_in_rt;
            w_word[15:11] = i_in_rd;
        end else if (w_is_itype) begin
            w_word[25:21] = i_in_rs;
            w_word[20:16] = i_in_rt;
            w_word[15:0]  = i_in_imm;
        end else if (w_is_jr) begin
            w_word[25:21] = i_in_rs;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_write     = 1'b0;
        w_set_ill   = 1'b0;
        w_set_ovf   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_state_nxt = S_LOAD;
                    w_clear     = 1'b1;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (w_is_illegal) begin
                        w_set_ill   = 1'b1;
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_write = 1'b1;
                        if (w_is_halt) begin
                            w_state_nxt = S_DONE;
                        end else if (w_last) begin
                            w_set_ovf   = 1'b1;
                            w_state_nxt = S_ERROR;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr         <= '0;
            r_count        <= '0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_err_illegal  <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_mem_we <= w_write;
            if (w_clear) begin
                r_addr         <= '0;
                r_count        <= '0;
                r_err_illegal  <= 1'b0;
                r_err_overflow <= 1'b0;
            end
            if (w_write) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= w_word;
                r_count     <= r_count + 1'b1;
                // Saturate at the top word so the pointer never wraps onto address 0.
                if (!w_last) begin
                    r_addr <= r_addr + 1'b1;
                end
            end
            if (w_set_ill) begin
                r_err_illegal <= 1'b1;
            end
            if (w_set_ovf) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    assign o_in_ready     = (r_state == S_LOAD);
    assign o_busy         = (r_state == S_LOAD);
    assign o_done         = (r_state == S_DONE);
    assign o_mem_we       = r_mem_we;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_instr_count  = r_count;
    assign o_err_illegal  = r_err_illegal;
    assign o_err_overflow = r_err_overflow;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a full-depth instance and a DEPTH=4 instance
// share one stimulus stream; expected words are hand-encoded constants.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  in_opcode = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [15:0] in_imm = '0;

    logic        a_ready, a_we, a_busy, a_done, a_ill, a_ovf;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata;
    logic [10:0] a_count;

    logic        b_ready, b_we, b_busy, b_done, b_ill, b_ovf;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.DEPTH(1024)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
        .o_in_ready(a_ready), .i_in_opcode(in_opcode), .i_in_rs(in_rs),
        .i_in_rt(in_rt), .i_in_rd(in_rd), .i_in_imm(in_imm),
        .o_mem_we(a_we), .o_mem_addr(a_addr), .o_mem_wdata(a_wdata),
        .o_busy(a_busy), .o_done(a_done), .o_instr_count(a_count),
        .o_err_illegal(a_ill), .o_err_overflow(a_ovf)
    );

    instr_encoder_loader #(.DEPTH(4)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
        .o_in_ready(b_ready), .i_in_opcode(in_opcode), .i_in_rs(in_rs),
        .i_in_rt(in_rt), .i_in_rd(in_rd), .i_in_imm(in_imm),
        .o_mem_we(b_we), .o_mem_addr(b_addr), .o_mem_wdata(b_wdata),
        .o_busy(b_busy), .o_done(b_done), .o_instr_count(b_count),
        .o_err_illegal(b_ill), .o_err_overflow(b_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
        in_valid  = v;
        in_opcode = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_we",    32'(a_we),    32'd0);
        chk("rst_busy",  32'(a_busy),  32'd0);
        chk("rst_done",  32'(a_done),  32'd0);
        chk("rst_ill",   32'(a_ill),   32'd0);
        chk("rst_ovf",   32'(a_ovf),   32'd0);
        chk("rst_addr",  32'(a_addr),  32'd0);
        chk("rst_wdata", a_wdata,      32'd0);
        chk("rst_count", 32'(a_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(a_ready), 32'd0);

        // add r3,r1,r2 then HALT
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy",  32'(a_busy),  32'd1);
        chk("start_ready", 32'(a_ready), 32'd1);
        drive(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 16'h5555);
        tick();
        chk("add_we",    32'(a_we),    32'd1);
        chk("add_addr",  32'(a_addr),  32'd0);
        chk("add_word",  a_wdata,      32'h00221800);
        chk("add_count", 32'(a_count), 32'd1);
        drive(1'b1, 6'h11, 5'd5, 5'd6, 5'd7, 16'hABCD);
        tick();
        chk("halt_we",    32'(a_we),    32'd1);
        chk("halt_addr",  32'(a_addr),  32'd1);
        chk("halt_word",  a_wdata,      32'h44000000);
        chk("halt_done",  32'(a_done),  32'd1);
        chk("halt_ready", 32'(a_ready), 32'd0);
        chk("halt_count", 32'(a_count), 32'd2);
        tick();
        chk("done_we_low", 32'(a_we),   32'd0);
        chk("done_hold",   32'(a_done), 32'd1);
        drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0000);

        // field forcing across types
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_count", 32'(a_count), 32'd0);
        chk("restart_done",  32'(a_done),  32'd0);
        drive(1'b1, 6'h01, 5'd4, 5'd5, 5'd31, 16'hFFFF);
        tick();
        chk("addi_addr", 32'(a_addr), 32'd0);
        chk("addi_word", a_wdata,     32'h0485FFFF);
        drive(1'b1, 6'h10, 5'd7, 5'd9, 5'd9, 16'h1234);
        tick();
        chk("jr_addr", 32'(a_addr), 32'd1);
        chk("jr_word", a_wdata,     32'h40E00000);
        drive(1'b1, 6'h0E, 5'd31, 5'd0, 5'd17, 16'h00FF);
        tick();
        chk("i0e_word", a_wdata, 32'h3BE000FF);
        drive(1'b1, 6'h0A, 5'd0, 5'd31, 5'd31, 16'hFFFF);
        tick();
        chk("r0a_addr", 32'(a_addr), 32'd3);
        chk("r0a_word", a_wdata,     32'h281FF800);
        drive(1'b1, 6'h11, 5'd0, 5'd0, 5'd0, 16'h0000);
        tick();
        chk("halt2_count", 32'(a_count), 32'd5);
        drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0000);

        // illegal opcode; start inside LOAD ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        drive(1'b1, 6'h03, 5'd1, 5'd1, 5'd0, 16'h0001);
        tick();
        chk("ld1_word", a_wdata, 32'h0C210001);
        start = 1'b1;
        drive(1'b1, 6'h02, 5'd0, 5'd0, 5'd1, 16'h0000);
        tick();
        start = 1'b0;
        chk("ignstart_addr",  32'(a_addr),  32'd1);
        chk("ignstart_count", 32'(a_count), 32'd2);
        drive(1'b1, 6'h12, 5'd3, 5'd3, 5'd3, 16'h3333);
        tick();
        chk("ill_flag",  32'(a_ill),   32'd1);
        chk("ill_we",    32'(a_we),    32'd0);
        chk("ill_ready", 32'(a_ready), 32'd0);
        chk("ill_count", 32'(a_count), 32'd2);
        chk("ill_busy",  32'(a_busy),  32'd0);

        // start coincident with valid in ERROR: fields not taken
        start = 1'b1;
        drive(1'b1, 6'h00, 5'd2, 5'd2, 5'd2, 16'h0000);
        tick();
        start = 1'b0;
        chk("errstart_we",    32'(a_we),    32'd0);
        chk("errstart_ill",   32'(a_ill),   32'd0);
        chk("errstart_ready", 32'(a_ready), 32'd1);
        chk("errstart_count", 32'(a_count), 32'd0);
        tick();
        chk("errstart_wr_we",   32'(a_we),   32'd1);
        chk("errstart_wr_addr", 32'(a_addr), 32'd0);
        chk("errstart_wr_word", a_wdata,     32'h00421000);

        // in_valid toggling
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 6'h02, 5'd0, 5'd0, 5'(i), 16'h0000);
            tick();
            chk("tog_gap_we", 32'(a_we), 32'd0);
            drive(1'b1, 6'h02, 5'd0, 5'd0, 5'(i), 16'h0000);
            tick();
            chk("tog_we",   32'(a_we),   32'd1);
            chk("tog_addr", 32'(a_addr), 32'(i));
            chk("tog_word", a_wdata,     32'h08000000 | (32'(i) << 11));
        end

        // reset one cycle after an accept
        drive(1'b1, 6'h05, 5'd1, 5'd2, 5'd0, 16'h00AA);
        tick();
        chk("prerst_we",   32'(a_we),   32'd1);
        chk("prerst_addr", 32'(a_addr), 32'd4);
        rst = 1'b1;
        #1;
        chk("midrst_we",    32'(a_we),    32'd0);
        chk("midrst_busy",  32'(a_busy),  32'd0);
        chk("midrst_ready", 32'(a_ready), 32'd0);
        chk("midrst_count", 32'(a_count), 32'd0);
        chk("midrst_addr",  32'(a_addr),  32'd0);
        chk("midrst_wdata", a_wdata,      32'd0);
        drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        chk("postrst_ready", 32'(a_ready), 32'd0);

        // overflow on the DEPTH=4 instance
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 6'h01, 5'd0, 5'd0, 5'd0, 16'(k));
            tick();
            chk("ovf_we",   32'(b_we),    32'd1);
            chk("ovf_addr", 32'(b_addr),  32'(k - 1));
            chk("ovf_word", b_wdata,      32'h04000000 | 32'(k));
            chk("ovf_flag", 32'(b_ovf),   (k == 4) ? 32'd1 : 32'd0);
        end
        drive(1'b1, 6'h01, 5'd0, 5'd0, 5'd0, 16'd5);
        chk("ovf_ready_after", 32'(b_ready), 32'd0);
        tick();
        chk("ovf_fifth_we",  32'(b_we),    32'd0);
        chk("ovf_count",     32'(b_count), 32'd4);
        chk("ovf_addr_hold", 32'(b_addr),  32'd3);
        chk("ovf_sticky",    32'(b_ovf),   32'd1);
        chk("big_no_ovf",    32'(a_ovf),   32'd0);
        chk("big_addr",      32'(a_addr),  32'd4);
        drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0000);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
